spi_fifo_readout: RTL
=====================

Name: spi_fifo_readout

Overview:
- Dual-lane event readout buffer sitting directly upstream of the quad-SPI peripheral.
- Accepts 16-bit event words from the pixel/event front end on the system clock.
- Stores each lane in its own circular FIFO and presents the head word of each lane on registered outputs that the SPI peripheral reads as rdata_spi_0 / rdata_spi_1 during opcode 3'b111 streaming.
- Advances the outputs when the SPI peripheral's shift_en_fifo pulses, which arrive from the SCK domain and are synchronised here.

Parameters:
- DEPTH, 16, entries per lane FIFO; power of two, at least 2.
- WIDTH, 16, event word width; must match the SPI FIFO read port.
- EMPTY_WORD, 16'hFFFF, value driven on a lane output when it holds no valid word.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- ev_valid  input  2  per-lane push request from the event source.
- ev_data_0  input  WIDTH  lane 0 push data.
- ev_data_1  input  WIDTH  lane 1 push data.
- ev_ready  output  2  per-lane push accept; equals ~full.
- shift_en_fifo  input  2  per-lane pop request from the SPI peripheral (SCK domain, asynchronous to clk).
- flush  input  1  synchronous clear of both lanes (regfile control bit).
- rdata_spi_0  output  WIDTH  lane 0 registered head word.
- rdata_spi_1  output  WIDTH  lane 1 registered head word.
- out_valid  output  2  per-lane flag: rdata_spi_x holds a real word.
- level_0  output  $clog2(DEPTH)+1  lane 0 FIFO storage occupancy (output register excluded).
- level_1  output  $clog2(DEPTH)+1  lane 1 occupancy.
- overflow  output  2  sticky per lane: ev_valid seen while full.
- underflow  output  2  sticky per lane: pop seen while out_valid=0.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, rst_n.
- Reset values: rd/wr pointers 0, levels 0, ev_ready=2'b11, rdata_spi_x=EMPTY_WORD, out_valid=0, overflow=0, underflow=0, sync flops 0.
- The two lanes are fully independent. Everything below applies per lane i.
- Push:
  - ev_ready[i] = (level_i != DEPTH).
  - Push occurs when ev_valid[i] & ev_ready[i]: write at wr_ptr, wr_ptr wraps DEPTH-1 -> 0, level +1.
  - ev_valid[i] while full: data dropped, overflow[i] set.
- Pop synchroniser:
  - shift_en_fifo[i] passes through 2 flops, then a third flop for edge detection.
  - pop_i = rising edge of the synchronised bit, a 1-cycle pulse.
  - Latency: pop_i occurs 3 clk edges after the shift_en_fifo rising edge.
  - A held-high shift_en produces exactly one pop.
- Output register, first-word-fall-through:
  - Load state: if out_valid[i]=0 and level_i>0 and no pop this cycle, rdata <= mem[rd_ptr], rd_ptr++, level -1, out_valid <= 1.
  - On pop_i with out_valid=1 and level>0: rdata <= mem[rd_ptr], rd_ptr++, level -1, out_valid stays 1.
  - On pop_i with out_valid=1 and level=0: rdata <= EMPTY_WORD, out_valid <= 0.
  - On pop_i with out_valid=0: underflow[i] set; rdata stays EMPTY_WORD.
- Simultaneous push and internal read in the same cycle: both take effect, level unchanged. A push into an empty lane with out_valid=0 reaches rdata 2 cycles after the push edge.
- Wrap-around: pointers are $clog2(DEPTH) bits; full/empty derive from level, never from pointer equality alone.
- flush:
  - Pointers and levels go to 0, rdata goes to EMPTY_WORD, out_valid goes to 0, sticky flags clear.
  - Flush has priority over a same-cycle push, pop, or load.
  - Sync flops are not cleared, so a pending edge still pops and sets underflow.
- Reset mid-operation: all state returns to reset values immediately. In-flight words are lost.
- Timing requirement: f_clk >= 8 x f_SCK. This guarantees the new rdata is stable before the SPI peripheral's next falling-edge sample following its cycle-14 shift pulse.
- rdata_spi_x and out_valid are driven only from flops.

Test Plan:
- Reset, then push lane0 16'h1234 -> ev_ready=2'b11 after reset; rdata_spi_0=16'h1234 and out_valid[0]=1 two clks after the push; level_0=0.
- Push lane0 16'hA000..16'hA003, then pulse shift_en_fifo[0] four times -> rdata_spi_0 steps A001, A002, A003, FFFF, each 3 clks after its pulse; out_valid[0]=0 after the fourth; underflow=0.
- Fill lane1 with DEPTH+1 words while no pop -> after DEPTH+1 accepted (1 in output reg + DEPTH stored), ev_ready[1]=0, level_1=16; an extra ev_valid sets overflow[1]=1; lane0 unaffected.
- Hold shift_en_fifo=2'b11 high for 20 clks with both lanes loaded -> exactly one pop per lane.
- Interleave pushes and pops across a pointer wrap (40 words through DEPTH=16) -> output order equals push order; level never exceeds 16.
- Assert flush with level_0=5 and overflow[0]=1 -> next cycle level_0=0, rdata_spi_0=FFFF, out_valid=0, overflow=0. Also assert rst_n low mid-stream -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/spi_fifo_readout.sv
// spi_fifo_readout: dual-lane event buffer feeding the quad-SPI FIFO read port.
// Each lane has a circular FIFO plus a registered head word (first-word-fall-through)
// that advances on a synchronised rising edge of shift_en_fifo from the SCK domain.
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   ev_valid/ev_ready   per-lane push handshake (ev_ready = not full)
//   ev_data_0/1         per-lane push data
//   shift_en_fifo       per-lane pop request (asynchronous, edge-detected)
//   flush               synchronous clear of both lanes
//   rdata_spi_0/1       per-lane registered head word (EMPTY_WORD when none)
//   out_valid           per-lane head-word valid
//   level_0/1           per-lane storage occupancy, head register excluded
//   overflow/underflow  sticky per-lane push-while-full / pop-while-empty flags
module spi_fifo_readout #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned WIDTH      = 16,
  parameter logic [WIDTH-1:0] EMPTY_WORD = {WIDTH{1'b1}}
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 ev_valid,
  input  logic [WIDTH-1:0]           ev_data_0,
  input  logic [WIDTH-1:0]           ev_data_1,
  output logic [1:0]                 ev_ready,
  input  logic [1:0]                 shift_en_fifo,
  input  logic                       flush,
  output logic [WIDTH-1:0]           rdata_spi_0,
  output logic [WIDTH-1:0]           rdata_spi_1,
  output logic [1:0]                 out_valid,
  output logic [$clog2(DEPTH):0]     level_0,
  output logic [$clog2(DEPTH):0]     level_1,
  output logic [1:0]                 overflow,
  output logic [1:0]                 underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] ev_data_arr [2];
  logic [WIDTH-1:0] rdata_arr   [2];
  logic [LW-1:0]    level_arr   [2];

  assign ev_data_arr[0] = ev_data_0;
  assign ev_data_arr[1] = ev_data_1;
  assign rdata_spi_0    = rdata_arr[0];
  assign rdata_spi_1    = rdata_arr[1];
  assign level_0        = level_arr[0];
  assign level_1        = level_arr[1];

  for (genvar g = 0; g < 2; g++) begin : g_lane
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             valid_q, valid_d;
    logic             ready_q, ready_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic [2:0]       sync_q;
    logic             pop;
    logic             push;
    logic             rd;

    // Next-state for pointers, occupancy, head register and sticky flags
    always_comb begin
      pop      = sync_q[1] & ~sync_q[2];
      push     = ev_valid[g] & ready_q;
      rd       = 1'b0;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      rdata_d  = rdata_q;
      valid_d  = valid_q;
      ovf_d    = ovf_q;
      udf_d    = udf_q;

      if (!valid_q && (level_q != '0) && !pop) begin
        rd = 1'b1;
      end else if (pop) begin
        if (valid_q) begin
          if (level_q != '0) begin
            rd = 1'b1;
          end else begin
            rdata_d = EMPTY_WORD;
            valid_d = 1'b0;
          end
        end else begin
          udf_d = 1'b1;
        end
      end

      if (rd) begin
        rdata_d  = mem_q[rd_ptr_q];
        rd_ptr_d = rd_ptr_q + AW'(1);
        valid_d  = 1'b1;
      end

      // Power-of-two depth: pointer increment wraps naturally
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (ev_valid[g] && !ready_q) ovf_d = 1'b1;

      level_d = level_q + LW'(push) - LW'(rd);
      ready_d = (level_d != LW'(DEPTH));

      // Flush beats any same-cycle push, pop or load; synchroniser is left alone
      if (flush) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        level_d  = '0;
        rdata_d  = EMPTY_WORD;
        valid_d  = 1'b0;
        ready_d  = 1'b1;
        ovf_d    = 1'b0;
        udf_d    = 1'b0;
      end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
        rdata_q  <= EMPTY_WORD;
        valid_q  <= 1'b0;
        ready_q  <= 1'b1;
        ovf_q    <= 1'b0;
        udf_q    <= 1'b0;
        sync_q   <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        level_q  <= level_d;
        rdata_q  <= rdata_d;
        valid_q  <= valid_d;
        ready_q  <= ready_d;
        ovf_q    <= ovf_d;
        udf_q    <= udf_d;
        sync_q   <= {sync_q[1:0], shift_en_fifo[g]};
      end
    end

    // Storage array, no reset needed: occupancy alone defines validity
    always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_ptr_q] <= ev_data_arr[g];
    end

    assign ev_ready[g]  = ready_q;
    assign out_valid[g] = valid_q;
    assign overflow[g]  = ovf_q;
    assign underflow[g] = udf_q;
    assign rdata_arr[g] = rdata_q;
    assign level_arr[g] = level_q;
  end

endmodule
